// File: rtl/operand_read.sv
// operand_read: fetches two source operands (Rn, Rm) from the register file
// into held A/B operand registers, one per cycle, then pulses done.
// Optional feature macro: OPERAND_READ_BYPASS_EN. When it is defined, a
// register-file write that lands in the same cycle as a read forwards data_in
// into the operand register.
module operand_read #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [width-1:0] reg0,
  input  logic [width-1:0] reg1,
  input  logic [width-1:0] reg2,
  input  logic [width-1:0] reg3,
  input  logic [width-1:0] reg4,
  input  logic [width-1:0] reg5,
  input  logic [width-1:0] reg6,
  input  logic [width-1:0] reg7,
  input  logic             write,
  input  logic [2:0]       writenum,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] A,
  output logic [width-1:0] B,
  output logic [2:0]       readnum,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [2:0]       r_rnQ;
  logic [2:0]       r_rmQ;
  logic [width-1:0] r_a;
  logic [width-1:0] r_b;
  logic             w_latchIdx;
  logic             w_loadA;
  logic             w_loadB;
  logic [2:0]       w_readIdx;
  logic [width-1:0] w_regVal;
  logic [width-1:0] w_operand;

  // State register; reset drops any fetch in progress without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-state outputs; start is only honoured in IDLE.
  always_comb begin
    w_nextState = r_state;
    w_latchIdx  = 1'b0;
    w_loadA     = 1'b0;
    w_loadB     = 1'b0;
    w_readIdx   = 3'd0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_latchIdx  = 1'b1;
          w_nextState = READ_A;
        end
      end
      READ_A: begin
        w_readIdx   = r_rnQ;
        w_loadA     = 1'b1;
        w_nextState = READ_B;
      end
      READ_B: begin
        w_readIdx   = r_rmQ;
        w_loadB     = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Index being read is only meaningful in READ_A/READ_B; zero elsewhere.
  always_comb begin
    readnum = w_readIdx;
  end

  // Combinational register-file mux; every index 0-7 selects a real register.
  always_comb begin
    w_regVal = reg0;
    case (w_readIdx)
      3'd0: w_regVal = reg0;
      3'd1: w_regVal = reg1;
      3'd2: w_regVal = reg2;
      3'd3: w_regVal = reg3;
      3'd4: w_regVal = reg4;
      3'd5: w_regVal = reg5;
      3'd6: w_regVal = reg6;
      3'd7: w_regVal = reg7;
      default: w_regVal = reg0;
    endcase
  end

`ifdef OPERAND_READ_BYPASS_EN
  // Forward a same-cycle register write so the operand never sees stale data.
  always_comb begin
    w_operand = w_regVal;
    if (write && (writenum == w_readIdx)) begin
      w_operand = data_in;
    end
  end
`else
  // Write port kept for interface stability only; operands come from the file.
  logic w_unusedWritePort;
  assign w_unusedWritePort = ^{write, writenum, data_in};

  // Operand value is the selected register-file output.
  always_comb begin
    w_operand = w_regVal;
  end
`endif

  // Index latches and operand holding registers; A/B persist across IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rnQ <= 3'd0;
      r_rmQ <= 3'd0;
      r_a   <= '0;
      r_b   <= '0;
    end else begin
      if (w_latchIdx) begin
        r_rnQ <= rn;
        r_rmQ <= rm;
      end
      if (w_loadA) begin
        r_a <= w_operand;
      end
      if (w_loadB) begin
        r_b <= w_operand;
      end
    end
  end

  assign A = r_a;
  assign B = r_b;

endmodule

// File: tb/tb_operand_read.sv
// tb_operand_read: self-checking bench for operand_read with a scoreboard of
// expected A/B pairs that is drained on every done pulse.
module tb_operand_read;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   rn;
  logic [2:0]   rm;
  logic [W-1:0] regs [8];
  logic         write;
  logic [2:0]   writenum;
  logic [W-1:0] data_in;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   readnum;
  logic         busy;
  logic         done;

  int totalChecks = 0;
  int badChecks   = 0;
  pair_t expQ[$];

  operand_read #(.width(W)) dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm),
    .reg0(regs[0]), .reg1(regs[1]), .reg2(regs[2]), .reg3(regs[3]),
    .reg4(regs[4]), .reg5(regs[5]), .reg6(regs[6]), .reg7(regs[7]),
    .write(write), .writenum(writenum), .data_in(data_in),
    .A(A), .B(B), .readnum(readnum), .busy(busy), .done(done)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the fetch request inputs
  task automatic applyStimulus(input logic s, input logic [2:0] n, input logic [2:0] m);
    start = s;
    rn    = n;
    rm    = m;
  endtask

  // Advance to just after the next active edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: every done pulse must match the oldest queued fetch
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'(done), 32'd0);
      end else begin
        pair_t e;
        e = expQ.pop_front();
        checkOutput("sbA", 32'(A), 32'(e.a));
        checkOutput("sbB", 32'(B), 32'(e.b));
      end
    end
  end

  initial begin
    logic [W-1:0] bypassExp;
    reset    = 1'b0;
    start    = 1'b0;
    rn       = 3'd0;
    rm       = 3'd0;
    write    = 1'b0;
    writenum = 3'd0;
    data_in  = '0;
    for (int i = 0; i < 8; i++) regs[i] = W'(16'h1000 + i);

    // Reset asserted mid-cycle takes effect immediately
    #2 reset = 1'b1;
    #1;
    checkOutput("rstA", 32'(A), 32'd0);
    checkOutput("rstB", 32'(B), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstReadnum", 32'(readnum), 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleA", 32'(A), 32'd0);

    // Basic fetch rn=3, rm=5
    regs[3] = 16'h1234;
    regs[5] = 16'hABCD;
    applyStimulus(1'b1, 3'd3, 3'd5);
    expQ.push_back('{a: 16'h1234, b: 16'hABCD});
    cyc();
    applyStimulus(1'b0, 3'd0, 3'd0);
    checkOutput("t0Busy", 32'(busy), 32'd1);
    checkOutput("t0Readnum", 32'(readnum), 32'd3);
    checkOutput("t0Done", 32'(done), 32'd0);
    cyc();
    checkOutput("t1A", 32'(A), 32'h1234);
    checkOutput("t1Readnum", 32'(readnum), 32'd5);
    checkOutput("t1Done", 32'(done), 32'd0);
    cyc();
    checkOutput("t2B", 32'(B), 32'hABCD);
    checkOutput("t2Done", 32'(done), 32'd1);
    checkOutput("t2Busy", 32'(busy), 32'd1);
    checkOutput("t2Readnum", 32'(readnum), 32'd0);
    cyc();
    checkOutput("t3Done", 32'(done), 32'd0);
    checkOutput("t3Busy", 32'(busy), 32'd0);
    checkOutput("t3HoldA", 32'(A), 32'h1234);

    // Same index, start re-pulsed in READ_A and DONE, rn changed while busy
    regs[2] = 16'h0F0F;
    applyStimulus(1'b1, 3'd2, 3'd2);
    expQ.push_back('{a: 16'h0F0F, b: 16'h0F0F});
    cyc();
    applyStimulus(1'b1, 3'd7, 3'd6);
    checkOutput("sameReadnumA", 32'(readnum), 32'd2);
    cyc();
    applyStimulus(1'b0, 3'd7, 3'd6);
    checkOutput("sameReadnumB", 32'(readnum), 32'd2);
    cyc();
    applyStimulus(1'b1, 3'd7, 3'd6);
    checkOutput("sameDone", 32'(done), 32'd1);
    cyc();
    applyStimulus(1'b0, 3'd0, 3'd0);
    checkOutput("ignoredStartBusy", 32'(busy), 32'd0);
    cyc();
    checkOutput("ignoredStartIdle", 32'(busy), 32'd0);
    checkOutput("sameA", 32'(A), 32'h0F0F);
    checkOutput("sameB", 32'(B), 32'h0F0F);

    // Reset during READ_B abandons the fetch with no done pulse
    applyStimulus(1'b1, 3'd3, 3'd5);
    cyc();
    applyStimulus(1'b0, 3'd0, 3'd0);
    cyc();
    reset = 1'b1;
    #1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstA", 32'(A), 32'd0);
    checkOutput("midRstB", 32'(B), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    checkOutput("postRstIdle", 32'(busy), 32'd0);
    regs[1] = 16'h1111;
    regs[7] = 16'h7777;
    applyStimulus(1'b1, 3'd1, 3'd7);
    expQ.push_back('{a: 16'h1111, b: 16'h7777});
    cyc();
    applyStimulus(1'b0, 3'd0, 3'd0);
    cyc();
    cyc();
    cyc();
    checkOutput("afterRstA", 32'(A), 32'h1111);

    // Register changes between t1 and t2
    regs[4] = 16'h0001;
    applyStimulus(1'b1, 3'd4, 3'd4);
    expQ.push_back('{a: 16'h0001, b: 16'h0002});
    cyc();
    applyStimulus(1'b0, 3'd0, 3'd0);
    cyc();
    regs[4] = 16'h0002;
    cyc();
    cyc();

    // Write landing during READ_A on the index being read
`ifdef OPERAND_READ_BYPASS_EN
    bypassExp = 16'hBEEF;
`else
    bypassExp = 16'h0000;
`endif
    regs[6] = 16'h0000;
    regs[0] = 16'h5555;
    applyStimulus(1'b1, 3'd6, 3'd0);
    expQ.push_back('{a: bypassExp, b: 16'h5555});
    cyc();
    applyStimulus(1'b0, 3'd0, 3'd0);
    write    = 1'b1;
    writenum = 3'd6;
    data_in  = 16'hBEEF;
    cyc();
    write = 1'b0;
    checkOutput("bypassA", 32'(A), 32'(bypassExp));
    cyc();
    cyc();
    cyc();

    checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #20000;
    $display("[TB] FAIL timeout: got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/operand_read.md
Name: operand_read

Overview:
Read-side companion to the register-file write block.
- Sequentially fetches two source operands (Rn, Rm) from the eight register-file outputs into held A/B operand registers.
- Raises a one-cycle `done` pulse when both operands are valid.
- Sits between the register file and the ALU/shifter datapath. The controller drives it with a start/done handshake.

Parameters:
width, 16, bit width of each register and of the A/B operand outputs

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request an operand fetch; sampled only in IDLE
rn  input  3  register index for operand A
rm  input  3  register index for operand B
reg0..reg7  input  width each  current register-file contents
write  input  1  register-file write enable (used only with the optional feature)
writenum  input  3  register-file write index (used only with the optional feature)
data_in  input  width  register-file write data (used only with the optional feature)
A  output  width  operand A holding register
B  output  width  operand B holding register
readnum  output  3  index currently being read: rn_q in READ_A, rm_q in READ_B, else 0
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: A and B both valid

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: state=IDLE, A=0, B=0, rn_q=0, rm_q=0, done=0, busy=0, readnum=0.
- FSM states: IDLE, READ_A, READ_B, DONE (2-bit encoding).
- IDLE:
  - if start=1 at a rising edge: latch rn->rn_q and rm->rm_q, go to READ_A.
  - otherwise stay in IDLE.
- READ_A: at the edge, A <= reg[rn_q], go to READ_B.
- READ_B: at the edge, B <= reg[rm_q], go to DONE.
- DONE:
  - done=1 for exactly this cycle; go to IDLE at the next edge.
  - start asserted in DONE is ignored.
- Latency: start sampled at edge t0; A valid after t1; B valid after t2; done high during the cycle between t2 and t3.
- After the first start, the controller may change rn and rm freely; only the values latched at t0 are used.
- start while busy=1 is ignored. No queuing, no error flag.
- A and B hold their values until overwritten by the next fetch; they are not cleared in IDLE.
- rn_q == rm_q is legal: A and B both read the same register, one cycle apart.
- Register contents change between t1 and t2: B reflects the value at edge t2, and A keeps its t1 value.
- Reset asserted mid-operation: all state clears immediately, no done pulse is produced, and the fetch is abandoned.
- Register mux is purely combinational on rn_q/rm_q. Indices 0-7 are all valid; there is no X default on the read path.

Optional Feature:
Macro OPERAND_READ_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If write=1 and writenum equals the index being read (rn_q in READ_A, rm_q in READ_B) at that edge, the operand register loads data_in instead of reg[index].
  - Net effect: an operand always reflects a write landing in the same cycle.
- Not defined: write, writenum and data_in are ignored (ports remain for interface stability), and operands load reg[index] only.

Test Plan:
- Reset then idle: assert reset mid-cycle -> A=0, B=0, busy=0, done=0 immediately; no state change without start.
- Basic fetch: reg3=16'h1234, reg5=16'hABCD; start with rn=3, rm=5 -> A=16'h1234 after t1, B=16'hABCD after t2, done=1 only in cycle t2-t3, busy=1 from t0 to t3.
- Same index and start-while-busy: rn=rm=2, reg2=16'h0F0F; re-pulse start in READ_A and in DONE -> A=B=16'h0F0F; exactly one done pulse; no second fetch begins.
- Reset mid-fetch: assert reset during READ_B -> state IDLE, A=B=0, no done; a following start with rn=1, rm=7 completes normally.
- Register update between reads: reg4 changes 16'h0001->16'h0002 between t1 and t2, rn=rm=4 -> A=16'h0001, B=16'h0002.
- Bypass (macro defined): during READ_A, write=1, writenum=rn_q=6, data_in=16'hBEEF while reg6=16'h0000 -> A=16'hBEEF. Macro undefined -> A=16'h0000.
